// File: rtl/ex_mul_wb_pkg.sv
// Shared JX2 core constants and payload types for the MUL3 writeback path.
// Optional feature macro: JX2_MULWB_SAT32_EN (signed 32-bit clamp of ixt-tagged results).
package ex_mul_wb_pkg;

  localparam int unsigned RegNW          = 7;
  localparam int unsigned IxtW           = 9;
  localparam int unsigned ValW           = 64;
  localparam int unsigned MulWbFifoDepth = 2;
  localparam int unsigned MulWbPtrW      = $clog2(MulWbFifoDepth);
  localparam int unsigned MulWbCntW      = $clog2(MulWbFifoDepth + 1);

  localparam logic [7:0]  JX2_UCMD_MUL3  = 8'h25;
  localparam int unsigned JX2_IXT_SAT32  = 3;

  typedef struct packed {
    logic             valid;
    logic [RegNW-1:0] regN;
    logic [IxtW-1:0]  ixt;
  } MulTag;

  typedef struct packed {
    logic [RegNW-1:0] regN;
    logic [ValW-1:0]  val;
  } MulWbEnt;

`ifdef JX2_MULWB_SAT32_EN
  // Clamp to the signed 32-bit range, result sign-extended to 64 bits.
  function automatic logic [ValW-1:0] sat32(input logic [ValW-1:0] v);
    logic fits;
    fits = (v[ValW-1:31] == '0) || (v[ValW-1:31] == '1);
    if (fits) return v;
    return v[ValW-1] ? {32'hFFFF_FFFF, 32'h8000_0000} : {32'h0000_0000, 32'h7FFF_FFFF};
  endfunction
`endif

endpackage

// File: rtl/ex_mul_wb_if.sv
// Execute-to-writeback handshake bundle for the MUL3 result path.
interface ex_mul_wb_if;
  import ex_mul_wb_pkg::*;

  logic                idMulVld;
  logic [RegNW-1:0]    idRegN;
  logic [IxtW-1:0]     idUIxt;
  logic                exHold;
  logic [ValW-1:0]     valRn;
  logic                wbReady;
  logic                wbValid;
  logic [RegNW-1:0]    wbRegN;
  logic [ValW-1:0]     wbVal;
  logic                mulHoldReq;
  logic                mulBusy;

  modport master (
    output idMulVld, idRegN, idUIxt, exHold, valRn, wbReady,
    input  wbValid, wbRegN, wbVal, mulHoldReq, mulBusy
  );

  modport slave (
    input  idMulVld, idRegN, idUIxt, exHold, valRn, wbReady,
    output wbValid, wbRegN, wbVal, mulHoldReq, mulBusy
  );

endinterface

// File: rtl/ex_mul_wb_fifo.sv
// Two-entry result queue between the multiplier EX3 capture and the writeback port.
module ex_mul_wb_fifo
  import ex_mul_wb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  MulWbEnt              pushData,
  input  logic                 pop,
  output MulWbEnt              headData_c,
  output logic [MulWbCntW-1:0] count
);

  MulWbEnt              mem [MulWbFifoDepth];
  logic [MulWbPtrW-1:0] rdPtr;
  logic [MulWbPtrW-1:0] wrPtr;

  // At full, a simultaneous push overwrites the slot being popped, so order holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem   <= '{default: '0};
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + MulWbPtrW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + MulWbPtrW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + MulWbCntW'(1);
        2'b01:   count <= count - MulWbCntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero when empty so stale data never reaches the port.
  assign headData_c = (count != '0) ? mem[rdPtr] : '0;

endmodule

// File: rtl/ex_mul_wb.sv
// MUL3 execute-to-writeback stage: tag pipe matching multiplier latency plus result queue.
// Optional feature macro: JX2_MULWB_SAT32_EN (clamp ixt-tagged results to signed 32-bit).
module ex_mul_wb
  import ex_mul_wb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  ex_mul_wb_if.slave mulIf
);

  MulTag                s1;
  MulTag                s2;
  MulTag                s3;
  logic [MulWbCntW-1:0] fifoCount;
  MulWbEnt              head_c;
  MulWbEnt              pushEnt_c;
  logic [ValW-1:0]      pushVal_c;
  logic                 pop_c;
  logic                 full_c;
  logic                 holdReq_c;
  logic                 advance_c;
  logic                 push_c;
  logic                 unusedIxt_c;

  assign full_c    = (fifoCount == MulWbCntW'(MulWbFifoDepth));
  assign pop_c     = (fifoCount != '0) && mulIf.wbReady;
  assign holdReq_c = full_c && s3.valid && !pop_c;
  // Our own hold request also freezes the pipe so no tag is lost if the core lags a cycle.
  assign advance_c = !mulIf.exHold && !holdReq_c;
  assign push_c    = s3.valid && advance_c;

  // Tag pipe tracks the multiplier EX1..EX3 stages one-for-one; issue is ignored while held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (advance_c) begin
      s1 <= '{valid: mulIf.idMulVld, regN: mulIf.idRegN, ixt: mulIf.idUIxt};
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef JX2_MULWB_SAT32_EN
  assign pushVal_c = s3.ixt[JX2_IXT_SAT32] ? sat32(mulIf.valRn) : mulIf.valRn;
`else
  assign pushVal_c = mulIf.valRn;
`endif

  assign unusedIxt_c = ^s3.ixt;
  assign pushEnt_c   = '{regN: s3.regN, val: pushVal_c};

  ex_mul_wb_fifo uFifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_c),
    .pushData   (pushEnt_c),
    .pop        (pop_c),
    .headData_c (head_c),
    .count      (fifoCount)
  );

  assign mulIf.wbValid    = (fifoCount != '0);
  assign mulIf.wbRegN     = head_c.regN;
  assign mulIf.wbVal      = head_c.val;
  assign mulIf.mulHoldReq = holdReq_c;
  assign mulIf.mulBusy    = s1.valid || s2.valid || s3.valid || (fifoCount != '0);

endmodule

// File: tb/tb_ex_mul_wb.sv
// Bench for ex_mul_wb: directed scenarios plus random traffic against a queue-based model.
module tb_ex_mul_wb;
  import ex_mul_wb_pkg::*;

`ifdef JX2_MULWB_SAT32_EN
  localparam bit SatOn = 1'b1;
`else
  localparam bit SatOn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic extHold;

  always #5 clock = ~clock;

  ex_mul_wb_if mIf ();
  assign mIf.exHold = extHold | mIf.mulHoldReq;

  ex_mul_wb dut (
    .clock (clock),
    .reset (reset),
    .mulIf (mIf)
  );

  typedef struct {
    logic [6:0]  regN;
    logic [8:0]  ixt;
    logic [63:0] val;
    int          age;
  } Op;

  typedef struct {
    logic [6:0]  regN;
    logic [63:0] val;
  } Ent;

  Op           inflight[$];
  Ent          fifoQ[$];
  int          popLog[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          firstWb = -1;
  int          wbPulses = 0;
  bit          issueTaken;
  bit          lastHold;
  logic [63:0] lastWbVal;
  logic [63:0] pendVal;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expectVal(input logic [8:0] ixt, input logic [63:0] v);
    longint s;
    s = signed'(v);
    if (SatOn && ixt[3]) begin
      if (s > 64'sd2147483647)  return 64'h0000_0000_7FFF_FFFF;
      if (s < -64'sd2147483648) return 64'hFFFF_FFFF_8000_0000;
    end
    return v;
  endfunction

  // One clock: check outputs at the falling edge, advance the model, then drive valRn.
  task automatic cycle();
    bit pop;
    bit expHold;
    bit effHold;
    bit s3Occupied;
    Ent e;
    Op  o;
    @(negedge clock);
    s3Occupied = (inflight.size() != 0) && (inflight[0].age == 3);
    pop        = (fifoQ.size() != 0) && mIf.wbReady;
    expHold    = (fifoQ.size() == 2) && s3Occupied && !pop;
    effHold    = extHold || expHold;

    chk("wbValid", mIf.wbValid, fifoQ.size() != 0);
    if (fifoQ.size() != 0) begin
      chk("wbRegN", mIf.wbRegN, fifoQ[0].regN);
      chk("wbVal", mIf.wbVal, fifoQ[0].val);
    end else begin
      chk("wbRegNIdle", mIf.wbRegN, 0);
      chk("wbValIdle", mIf.wbVal, 0);
    end
    chk("mulBusy", mIf.mulBusy, (inflight.size() != 0) || (fifoQ.size() != 0));
    chk("mulHoldReq", mIf.mulHoldReq, expHold);

    lastHold = mIf.mulHoldReq;
    if (mIf.wbValid) begin
      if (firstWb < 0) firstWb = cyc;
      wbPulses++;
      lastWbVal = mIf.wbVal;
    end
    if (pop) begin
      popLog.push_back(int'(fifoQ[0].regN));
      void'(fifoQ.pop_front());
    end

    issueTaken = 1'b0;
    if (!effHold) begin
      if (s3Occupied) begin
        o = inflight.pop_front();
        e.regN = o.regN;
        e.val  = expectVal(o.ixt, o.val);
        fifoQ.push_back(e);
      end
      foreach (inflight[i]) inflight[i].age++;
      if (mIf.idMulVld) begin
        o.regN = mIf.idRegN;
        o.ixt  = mIf.idUIxt;
        o.val  = pendVal;
        o.age  = 1;
        inflight.push_back(o);
        issueTaken = 1'b1;
      end
    end
    chk("noOverflow", fifoQ.size() <= 2, 1);

    @(posedge clock);
    #1;
    cyc++;
    if ((inflight.size() != 0) && (inflight[0].age == 3)) mIf.valRn = inflight[0].val;
    else mIf.valRn = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [6:0] r, input logic [8:0] x, input logic [63:0] v);
    mIf.idMulVld = 1'b1;
    mIf.idRegN   = r;
    mIf.idUIxt   = x;
    pendVal      = v;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (issueTaken) break;
      extHold      = 1'b0;
      mIf.wbReady  = 1'b1;
    end
    if (!issueTaken) chk("issueTimeout", 0, 1);
    mIf.idMulVld = 1'b0;
    mIf.idRegN   = 7'($urandom);
    mIf.idUIxt   = 9'($urandom);
  endtask

  task automatic resetOutputs(input string tag);
    chk({tag, "_wbValid"}, mIf.wbValid, 0);
    chk({tag, "_wbRegN"}, mIf.wbRegN, 0);
    chk({tag, "_wbVal"}, mIf.wbVal, 0);
    chk({tag, "_hold"}, mIf.mulHoldReq, 0);
    chk({tag, "_busy"}, mIf.mulBusy, 0);
  endtask

  initial begin
    int t0;
    logic [63:0] v;
    reset        = 1'b1;
    extHold      = 1'b0;
    mIf.idMulVld = 1'b0;
    mIf.idRegN   = '0;
    mIf.idUIxt   = '0;
    mIf.valRn    = '0;
    mIf.wbReady  = 1'b0;
    #1 reset = 1'b0;
    #1 resetOutputs("por");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Single op: result appears exactly 4 cycles after issue, one cycle wide.
    mIf.wbReady = 1'b1;
    firstWb = -1; wbPulses = 0; t0 = cyc;
    issue(7'd5, 9'h000, 64'h1234);
    repeat (6) cycle();
    chk("lat1", firstWb - t0, 4);
    chk("pulse1", wbPulses, 1);
    chk("val1", lastWbVal, 64'h1234);

    // Three back-to-back ops with writeback blocked, then released.
    mIf.wbReady = 1'b0;
    popLog.delete();
    issue(7'd1, 9'h000, {$urandom, $urandom});
    issue(7'd2, 9'h000, {$urandom, $urandom});
    issue(7'd3, 9'h000, {$urandom, $urandom});
    repeat (2) cycle();
    cycle();
    chk("holdRaised", lastHold, 1);
    mIf.wbReady = 1'b1;
    cycle();
    chk("holdDropOnPop", lastHold, 0);
    mIf.wbReady = 1'b0;
    repeat (2) cycle();
    chk("pairPending", popLog.size(), 1);
    mIf.wbReady = 1'b1;
    repeat (4) cycle();
    chk("orderCount", popLog.size(), 3);
    if (popLog.size() == 3) begin
      chk("order0", popLog[0], 1);
      chk("order1", popLog[1], 2);
      chk("order2", popLog[2], 3);
    end

    // Five-cycle pipeline hold with the op sitting in S2.
    firstWb = -1; wbPulses = 0; t0 = cyc;
    issue(7'd9, 9'h000, {$urandom, $urandom});
    cycle();
    extHold = 1'b1;
    repeat (5) cycle();
    extHold = 1'b0;
    repeat (6) cycle();
    chk("latHold", firstWb - t0, 9);
    chk("pulseHold", wbPulses, 1);

    // Saturation tagging (clamp only when the feature is built in).
    issue(7'd11, 9'h008, 64'h0000_0001_0000_0000);
    repeat (5) cycle();
    chk("satPos", lastWbVal, SatOn ? 64'h0000_0000_7FFF_FFFF : 64'h0000_0001_0000_0000);
    issue(7'd12, 9'h008, 64'hFFFF_FFFF_0000_0000);
    repeat (5) cycle();
    chk("satNeg", lastWbVal, SatOn ? 64'hFFFF_FFFF_8000_0000 : 64'hFFFF_FFFF_0000_0000);
    issue(7'd13, 9'h000, 64'h0000_0001_0000_0000);
    repeat (5) cycle();
    chk("satUntagged", lastWbVal, 64'h0000_0001_0000_0000);

    // Reset with two queued results and one op in flight.
    mIf.wbReady = 1'b0;
    issue(7'd21, 9'h000, {$urandom, $urandom});
    issue(7'd22, 9'h000, {$urandom, $urandom});
    issue(7'd23, 9'h000, {$urandom, $urandom});
    repeat (2) cycle();
    chk("preResetBusy", mIf.mulBusy, 1);
    chk("preResetValid", mIf.wbValid, 1);
    reset = 1'b0;
    #1 resetOutputs("midReset");
    inflight.delete();
    fifoQ.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    mIf.wbReady = 1'b1;
    firstWb = -1;
    repeat (6) cycle();
    chk("noStale", firstWb, -1);
    firstWb = -1; wbPulses = 0; t0 = cyc;
    issue(7'd30, 9'h000, 64'hABCD);
    repeat (5) cycle();
    chk("postResetLat", firstWb - t0, 4);

    // Random traffic with random writeback back-pressure and pipeline holds.
    for (int n = 0; n < 1500; n++) begin
      mIf.wbReady = ($urandom_range(0, 3) != 0);
      extHold     = ($urandom_range(0, 7) == 0);
      if (!extHold && ($urandom_range(0, 1) == 1)) begin
        if ($urandom_range(0, 1) == 1) v = {{32{1'b0}}, $urandom} << $urandom_range(0, 32);
        else v = {$urandom, $urandom};
        issue(7'($urandom), 9'($urandom), v);
      end else begin
        cycle();
      end
    end

    extHold = 1'b0;
    mIf.wbReady = 1'b1;
    repeat (12) cycle();
    chk("drainBusy", mIf.mulBusy, 0);
    chk("drainValid", mIf.wbValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mul_wb.md
EX_MUL_WB -- requirements
Module: ex_mul_wb

Interface
REQ-001 SHALL have port: clock  in  1  core clock, all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: idMulVld in 1 (MUL3 op issued this cycle); idRegN in 7 (destination register); idUIxt in 9 (op sub-code).
REQ-004 SHALL have ports: exHold in 1 (pipeline hold); valRn in 64 (multiplier EX3 result, valid 3 unstalled cycles after issue).
REQ-005 SHALL have ports: wbReady in 1 (writeback port accepts this cycle); wbValid out 1; wbRegN out 7; wbVal out 64.
REQ-006 SHALL have ports: mulHoldReq out 1 (request pipeline hold); mulBusy out 1 (any op in flight or queued).

Function
REQ-007 SHALL carry {valid, regN, ixt} through a 3-stage tag pipe S1..S3 that advances only when exHold=0, matching multiplier latency exactly.
REQ-008 SHALL, while exHold=1, freeze the tag pipe with no loss or duplication of tags.
REQ-009 SHALL capture {S3.regN, valRn} into a 2-entry FIFO in the cycle S3.valid=1 and exHold=0.
REQ-010 SHALL present FIFO head on wbValid/wbRegN/wbVal combinationally from registers; a pop occurs when wbValid=1 and wbReady=1.
REQ-011 SHALL permit push and pop in the same cycle, including at count 2 (count unchanged, ordering preserved).
REQ-012 SHALL use 1-bit read/write pointers wrapping modulo 2 and a 2-bit count in 0..2.
REQ-013 SHALL assert mulHoldReq combinationally when count=2, S3.valid=1 and no pop this cycle; the captured push is suppressed that cycle.
REQ-014 SHALL never overflow: push while count=2 without a pop is an illegal state; bench asserts against it.
REQ-015 SHALL drive wbVal=0 and wbRegN=0 whenever wbValid=0.
REQ-016 SHALL assert mulBusy when any of S1..S3 valid or count!=0.
REQ-017 SHALL preserve issue order end to end; minimum issue-to-wbValid latency is 4 cycles.

Reset
REQ-018 SHALL, on reset low, asynchronously clear all S1..S3 valid bits, pointers, count, FIFO data.
REQ-019 SHALL hold outputs at reset: wbValid=0, wbRegN=0, wbVal=0, mulHoldReq=0, mulBusy=0.
REQ-020 SHALL discard in-flight and queued results on reset mid-operation; first post-reset issue behaves as from empty.

Configuration
REQ-021 SHALL honour macro JX2_MULWB_SAT32_EN.
REQ-022 SHALL, with JX2_MULWB_SAT32_EN defined, clamp pushed values whose ixt[3]=1 to signed 32-bit (0x7FFFFFFF / 0xFFFFFFFF80000000, sign-extended) before FIFO write.
REQ-023 SHALL, without the macro, store valRn unmodified; ixt[3] ignored; no saturation logic present.

Structure
REQ-024 SHALL take JX2_UCMD_MUL3 and the ixt bit assignments from the shared core constants package; FIFO depth constant (2) defined there.
REQ-025 SHALL implement the FIFO as one sub-module ex_mul_wb_fifo (2-entry, 71-bit, push/pop/count); tag pipe and hold logic remain in the parent.

Verification
REQ-026 SHALL cover: issue regN=5, valRn=0x1234 at EX3, wbReady=1 -> wbValid=1, wbRegN=5, wbVal=0x1234 exactly 4 cycles after issue, one cycle wide.
REQ-027 SHALL cover: 3 back-to-back issues (regN 1,2,3), wbReady=0 -> third arrival raises mulHoldReq; wbReady=1 next -> outputs 1,2,3 in order, hold drops same cycle as first pop.
REQ-028 SHALL cover: exHold=1 for 5 cycles with op at S2 -> wbValid delayed by exactly 5 cycles, single output.
REQ-029 SHALL cover: count=2, push and pop same cycle -> count stays 2, order intact, mulHoldReq=0.
REQ-030 SHALL cover: reset low with 2 queued + 1 in flight -> all outputs 0 immediately, mulBusy=0, no stale output after release.
REQ-031 SHALL cover (macro on): ixt[3]=1, valRn=0x0000000100000000 -> wbVal=0x000000007FFFFFFF; macro off -> wbVal=0x0000000100000000.
